// File: rtl/eth_rx_pack_buf.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | eth_rx_pack_buf : packs the RX MAC byte stream into 64-bit words, holds   |
// | good frames in NSLOT slots and queues {slot, length} for the host.       |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
module eth_rx_pack_buf #(
  parameter int NSLOT      = 4,
  parameter int SLOT_WORDS = 192,
  parameter int MIN_LEN    = 14,
  parameter int SW         = $clog2(NSLOT),
  parameter int AW         = $clog2(NSLOT*SLOT_WORDS),
  parameter int LW         = $clog2(SLOT_WORDS*8+1)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [7:0]    rx_data_i,
  input  logic          rx_valid_i,
  input  logic          rx_last_i,
  input  logic          rx_err_i,
  input  logic          host_rd_en_i,
  input  logic [AW-1:0] host_rd_addr_i,
  output logic [63:0]   host_rd_data_o,
  output logic          frm_avail_o,
  output logic [SW-1:0] frm_slot_o,
  output logic [LW-1:0] frm_len_o,
  input  logic          frm_release_i,
  output logic [15:0]   drop_cnt_o
);

  localparam logic [LW-1:0] c_slot_bytes = LW'(SLOT_WORDS*8);
  localparam logic [LW-1:0] c_min_len    = LW'(MIN_LEN);
  localparam logic [SW:0]   c_nslot      = (SW+1)'(NSLOT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RECV = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [LW-1:0] r_cnt;
  logic [63:0]   r_pack;
  logic [SW-1:0] r_wr_slot;
  logic [SW-1:0] r_head;
  logic [SW:0]   r_occ;
  logic [LW-1:0] r_len [NSLOT];
  logic [15:0]   r_drop_cnt;
  logic [63:0]   r_rd_data;
  logic [63:0]   r_mem [NSLOT*SLOT_WORDS];

  logic          w_full;
  logic          w_store;
  logic          w_commit;
  logic          w_drop;
  logic          w_rel;
  logic          w_wr_en;
  logic [LW-1:0] w_byte_idx;
  logic [LW-1:0] w_cnt_inc;
  logic [63:0]   w_wr_word;
  logic [AW-1:0] w_wr_addr;

  assign w_full     = (r_occ == c_nslot);
  assign w_rel      = frm_release_i && (r_occ != '0);
  // The first byte of a frame is always byte 0, whatever r_cnt was left at.
  assign w_byte_idx = (r_state == S_RECV) ? r_cnt : '0;
  assign w_cnt_inc  = w_byte_idx + LW'(1);
  // r_pack is cleared after every word write, so unfilled bytes read as zero.
  assign w_wr_word  = r_pack | ({56'd0, rx_data_i} << {w_byte_idx[2:0], 3'b000});
  assign w_wr_en    = w_store && ((w_byte_idx[2:0] == 3'd7) || rx_last_i);
  assign w_wr_addr  = AW'(r_wr_slot) * AW'(SLOT_WORDS) + AW'(w_byte_idx >> 3);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_store     = 1'b0;
    w_commit    = 1'b0;
    w_drop      = 1'b0;
    if (rx_valid_i) begin
      case (r_state)
        S_IDLE, S_RECV: begin
          if ((r_state == S_IDLE) && w_full) begin
            if (rx_last_i) w_drop = 1'b1;
            else           w_state_nxt = S_DROP;
          end else begin
            w_store = 1'b1;
            if (rx_last_i) begin
              if (!rx_err_i && (w_cnt_inc >= c_min_len)) w_commit = 1'b1;
              else                                       w_drop   = 1'b1;
              w_state_nxt = S_IDLE;
            end else if (w_cnt_inc == c_slot_bytes) begin
              w_state_nxt = S_DROP;
            end else begin
              w_state_nxt = S_RECV;
            end
          end
        end
        S_DROP: begin
          if (rx_last_i) begin
            w_drop      = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt      <= '0;
      r_pack     <= '0;
      r_wr_slot  <= '0;
      r_head     <= '0;
      r_occ      <= '0;
      r_drop_cnt <= '0;
      for (int i = 0; i < NSLOT; i++) r_len[i] <= '0;
    end else begin
      if (w_store) begin
        r_cnt  <= w_cnt_inc;
        r_pack <= w_wr_en ? 64'd0 : w_wr_word;
      end
      if (w_commit) begin
        r_len[r_wr_slot] <= w_cnt_inc;
        r_wr_slot        <= r_wr_slot + SW'(1);
      end
      if (w_rel) r_head <= r_head + SW'(1);
      case ({w_commit, w_rel})
        2'b10:   r_occ <= r_occ + (SW+1)'(1);
        2'b01:   r_occ <= r_occ - (SW+1)'(1);
        default: r_occ <= r_occ;
      endcase
      if (w_drop && (r_drop_cnt != 16'hFFFF)) r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[w_wr_addr] <= w_wr_word;
  end

  // Non-blocking read of the array gives old data on a same-word write.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)             r_rd_data <= '0;
    else if (host_rd_en_i) r_rd_data <= r_mem[host_rd_addr_i];
  end

  assign host_rd_data_o = r_rd_data;
  assign frm_avail_o    = (r_occ != '0);
  assign frm_slot_o     = r_head;
  assign frm_len_o      = r_len[r_head];
  assign drop_cnt_o     = r_drop_cnt;

endmodule
`default_nettype wire
